// File: rtl/janela_pkg.sv
// janela_pkg: shared types and default geometry for the 3x3 window builder
// that feeds the `mediana` median sorter.
//   DW_DEF       default pixel width in bits
//   LARGURA_DEF  default image width in pixels (>= 3)
//   ALTURA_DEF   default image height in lines (>= 3)
//   pixel_t      one pixel
//   janela_t     nine pixels, row-major, [0]=top-left .. [8]=bottom-right;
//                same shape as the sorter's `entrada`
package janela_pkg;
  localparam int DW_DEF      = 8;
  localparam int LARGURA_DEF = 8;
  localparam int ALTURA_DEF  = 8;

  typedef logic [DW_DEF-1:0] pixel_t;
  typedef pixel_t janela_t [8:0];
endpackage

// File: rtl/janela_3x3_if.sv
// janela_3x3_if: pixel input stream and window output stream of janela_3x3.
//   pix_in/pix_valid/pix_ready        raster-order pixel stream into the block
//   pix_sof                           start-of-frame marker (only with JANELA_SOF_EN)
//   janela/janela_valid/janela_ready  3x3 window stream out of the block
//   frame_done                        one-cycle pulse after a frame's last pixel
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. While valid is high and ready is low the producer holds its data
// and valid stable. ready may depend combinationally on the consumer's state.
//
// Modports: master = the pixel source / window consumer, slave = janela_3x3.
interface janela_3x3_if
  import janela_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
`ifdef JANELA_SOF_EN
  logic          pix_sof;
`endif
  logic [DW-1:0] janela [8:0];
  logic          janela_valid;
  logic          janela_ready;
  logic          frame_done;

`ifdef JANELA_SOF_EN
  modport master (output pix_in, pix_valid, pix_sof, janela_ready,
                  input  pix_ready, janela, janela_valid, frame_done);
  modport slave  (input  pix_in, pix_valid, pix_sof, janela_ready,
                  output pix_ready, janela, janela_valid, frame_done);
`else
  modport master (output pix_in, pix_valid, janela_ready,
                  input  pix_ready, janela, janela_valid, frame_done);
  modport slave  (input  pix_in, pix_valid, janela_ready,
                  output pix_ready, janela, janela_valid, frame_done);
`endif
endinterface

// File: rtl/janela_3x3_linha_buffer.sv
// linha_buffer: one image line of delay. The word at i_addr is read
// combinationally (the value stored one line ago) and replaced by i_din on
// the same clock edge when i_wr_en is high.
//   clk      system clock
//   i_wr_en  write strobe (pixel accepted)
//   i_addr   current column
//   i_din    pixel entering the line
//   o_dout   pixel stored at i_addr one line earlier
// Contents are deliberately not reset; the window logic never emits a
// window before two full lines have been written.
module linha_buffer
  import janela_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF,
  parameter int DW      = DW_DEF,
  parameter int AW      = $clog2(LARGURA)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);
  logic [DW-1:0] r_mem [LARGURA];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_addr] <= i_din;
  end

  assign o_dout = r_mem[i_addr];
endmodule

// File: rtl/janela_3x3.sv
// janela_3x3: builds 3x3 neighbourhoods from a raster-scan pixel stream and
// presents each interior one to the `mediana` sorter.
//   clk    system clock, rising edge
//   reset  synchronous, active-high; clears counters and drops any window
//   bus    janela_3x3_if.slave: pixel stream in, window stream out, frame_done
// Optional feature macro: JANELA_SOF_EN adds bus.pix_sof, which forces the
// accepted pixel to position (0,0) without dropping a pending window.
module janela_3x3
  import janela_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF,
  parameter int ALTURA  = ALTURA_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  janela_3x3_if.slave  bus
);
  localparam int CW = $clog2(LARGURA);
  localparam int RW = $clog2(ALTURA);
  localparam logic [CW-1:0] C_LAST = CW'(LARGURA - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ALTURA - 1);

  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [DW-1:0] r_win    [8:0];
  logic [DW-1:0] w_shift  [8:0];
  logic [DW-1:0] r_janela [8:0];
  logic [DW-1:0] w_lb0, w_lb1;
  logic          r_jv, r_fd;
  logic          w_pix_ready, w_accept, w_sof, w_emit, w_col_wrap, w_row_wrap;

`ifdef JANELA_SOF_EN
  assign w_sof = bus.pix_sof;
`else
  assign w_sof = 1'b0;
`endif

  // No skid buffer: a held window stalls the input in the same cycle.
  assign w_pix_ready = !r_jv || bus.janela_ready;
  assign w_accept    = bus.pix_valid && w_pix_ready;

  // Position of the pixel being offered; a start-of-frame pixel is (0,0).
  always_comb begin
    w_col      = w_sof ? '0 : r_col;
    w_row      = w_sof ? '0 : r_row;
    w_col_wrap = (w_col == C_LAST);
    w_row_wrap = (w_row == R_LAST);
    // Only interior centres: the right column of the window must be >= 2
    // columns and >= 2 rows into the image, so rows/columns 0-1 just refill.
    w_emit     = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
  end

  // lb0 holds the previous line, lb1 the line before it.
  linha_buffer #(.LARGURA(LARGURA), .DW(DW), .AW(CW)) u_lb0 (
    .clk    (clk),
    .i_wr_en(w_accept),
    .i_addr (w_col),
    .i_din  (bus.pix_in),
    .o_dout (w_lb0)
  );

  linha_buffer #(.LARGURA(LARGURA), .DW(DW), .AW(CW)) u_lb1 (
    .clk    (clk),
    .i_wr_en(w_accept),
    .i_addr (w_col),
    .i_din  (w_lb0),
    .o_dout (w_lb1)
  );

  // Window shifted one column left with the new column {lb1, lb0, pix_in}
  // entering on the right (top to bottom).
  always_comb begin
    for (int i = 0; i < 9; i++) w_shift[i] = '0;
    for (int r = 0; r < 3; r++) begin
      w_shift[r*3]     = r_win[r*3 + 1];
      w_shift[r*3 + 1] = r_win[r*3 + 2];
    end
    w_shift[2] = w_lb1;
    w_shift[5] = w_lb0;
    w_shift[8] = bus.pix_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_jv  <= 1'b0;
      r_fd  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i]    <= '0;
        r_janela[i] <= '0;
      end
    end else begin
      r_fd <= w_accept && w_col_wrap && w_row_wrap;
      if (w_accept) begin
        r_win <= w_shift;
        r_col <= w_col_wrap ? '0 : w_col + 1'b1;
        if (w_col_wrap) r_row <= w_row_wrap ? '0 : w_row + 1'b1;
        else            r_row <= w_row;
      end
      // A new window replaces a consumed one without a bubble.
      if (w_emit) begin
        r_janela <= w_shift;
        r_jv     <= 1'b1;
      end else if (bus.janela_ready) begin
        r_jv <= 1'b0;
      end
    end
  end

  assign bus.pix_ready    = w_pix_ready;
  assign bus.janela       = r_janela;
  assign bus.janela_valid = r_jv;
  assign bus.frame_done   = r_fd;
endmodule

// File: tb/tb_janela_3x3.sv
// tb_janela_3x3: directed bench for janela_3x3. A 4x4 instance covers the
// ramp, backpressure, back-to-back, mid-frame reset (and start-of-frame with
// JANELA_SOF_EN) cases; an 8x8 instance takes random pixels with janela_ready
// driven by a small sorter model whose done flag comes after a random delay.
module tb_janela_3x3;
  import janela_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus signals ----------------
  logic       sel;        // 0: 4x4 instance, 1: 8x8 instance
  logic       pv;
  logic       jr;
  logic [7:0] pin;
`ifdef JANELA_SOF_EN
  logic       psof;
`endif
  logic       sorter_on;
  int         wait_cnt;

  janela_3x3_if #(.DW(8)) a_if ();
  janela_3x3_if #(.DW(8)) b_if ();

  assign a_if.pix_in       = pin;
  assign a_if.pix_valid    = pv && !sel;
  assign a_if.janela_ready = jr;
  assign b_if.pix_in       = pin;
  assign b_if.pix_valid    = pv && sel;
  assign b_if.janela_ready = jr;
`ifdef JANELA_SOF_EN
  assign a_if.pix_sof      = psof;
  assign b_if.pix_sof      = psof;
`endif

  janela_3x3 #(.LARGURA(4), .ALTURA(4), .DW(8)) u4 (
    .clk  (clk),
    .reset(rst),
    .bus  (a_if.slave)
  );

  janela_3x3 #(.LARGURA(8), .ALTURA(8), .DW(8)) u8 (
    .clk  (clk),
    .reset(rst),
    .bus  (b_if.slave)
  );

  // Outputs of whichever instance is selected.
  logic        m_jv, m_pr, m_fd;
  logic [71:0] m_win;
  always_comb begin
    m_jv  = sel ? b_if.janela_valid : a_if.janela_valid;
    m_pr  = sel ? b_if.pix_ready    : a_if.pix_ready;
    m_fd  = sel ? b_if.frame_done   : a_if.frame_done;
    m_win = '0;
    for (int i = 0; i < 9; i++)
      m_win[i*8 +: 8] = sel ? b_if.janela[i] : a_if.janela[i];
  end

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q [$];
  int          acc_q [$];   // accepted-pixel count when each window is consumed
  int          fd_q  [$];   // accepted-pixel count at each frame_done pulse
  int          n_acc;
  int          n_total;
  int          n_bad;
  logic [71:0] mon_exp;
  logic [7:0]  img [64];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] ramp_win(input int base);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3 + c)*8 +: 8] = 8'(base + r*4 + c);
    return w;
  endfunction

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = w[i*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  // Monitor at the falling edge: a window valid with ready high now is
  // consumed at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_fd) fd_q.push_back(n_acc);
      if (m_jv && jr) begin
        acc_q.push_back(n_acc);
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL extra_window: got %h expected no window", m_win);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("window", m_win, mon_exp);
          if (sel) chk("median", 72'(med9(m_win)), 72'(med9(mon_exp)));
        end
      end
    end
  end

  // Sorter model for the 8x8 run: its done flag drives janela_ready.
  always @(posedge clk) begin
    #2;
    if (sorter_on) begin
      if (!m_jv) begin
        jr = 1'b0;
      end else if (wait_cnt == 0) begin
        jr = 1'b1;
        wait_cnt = $urandom_range(0, 3);
      end else begin
        jr = 1'b0;
        wait_cnt--;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic do_reset();
    rst = 1'b1;
    pv  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    acc_q.delete();
    fd_q.delete();
    n_acc = 0;
  endtask

  task automatic send_pix(input int v);
    bit got;
    got = 1'b0;
    pin = 8'(v);
    pv  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_pr) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL accept_timeout: pixel %0d not accepted, expected acceptance", v);
      @(posedge clk);
      #2 pv = 1'b0;
    end else begin
      @(posedge clk);
      #2;
      n_acc++;
      pv = 1'b0;
    end
  endtask

  task automatic push_ramp(input int off);
    exp_q.push_back(ramp_win(off + 0));
    exp_q.push_back(ramp_win(off + 1));
    exp_q.push_back(ramp_win(off + 4));
    exp_q.push_back(ramp_win(off + 5));
  endtask

  task automatic check_ramp(input string tag, input int off);
    chk({tag, "_left"}, 72'(exp_q.size()), 72'(0));
    chk({tag, "_nwin"}, 72'(acc_q.size()), 72'(4));
    if (acc_q.size() == 4) begin
      chk({tag, "_lat0"}, 72'(acc_q[0]), 72'(11 + off));
      chk({tag, "_lat1"}, 72'(acc_q[1]), 72'(12 + off));
      chk({tag, "_lat2"}, 72'(acc_q[2]), 72'(15 + off));
      chk({tag, "_lat3"}, 72'(acc_q[3]), 72'(16 + off));
    end
    chk({tag, "_nfd"}, 72'(fd_q.size()), 72'(1));
    if (fd_q.size() > 0) chk({tag, "_fdpos"}, 72'(fd_q[0]), 72'(16 + off));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_total = 0;
    n_bad = 0;
    n_acc = 0;
    sel = 1'b0;
    pv = 1'b0;
    jr = 1'b1;
    pin = '0;
    sorter_on = 1'b0;
    wait_cnt = 0;
`ifdef JANELA_SOF_EN
    psof = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 72'(m_jv), 72'(0));
    chk("rst_janela", m_win, 72'(0));
    chk("rst_fd", 72'(m_fd), 72'(0));
    chk("rst_ready", 72'(m_pr), 72'(1));
    @(posedge clk);
    #2;

    // Ramp, free-flowing
    clear_sb();
    push_ramp(0);
    for (int v = 0; v < 16; v++) send_pix(v);
    idle(6);
    check_ramp("ramp", 0);

    // Backpressure after the first window
    do_reset();
    clear_sb();
    push_ramp(0);
    jr = 1'b0;
    for (int v = 0; v <= 10; v++) send_pix(v);
    pin = 8'd11;
    pv  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 72'(m_pr), 72'(0));
      chk("bp_valid", 72'(m_jv), 72'(1));
      chk("bp_hold", m_win, ramp_win(0));
    end
    @(posedge clk);
    #2 jr = 1'b1;
    for (int v = 11; v < 16; v++) send_pix(v);
    idle(6);
    chk("bp_left", 72'(exp_q.size()), 72'(0));
    chk("bp_nwin", 72'(acc_q.size()), 72'(4));
    chk("bp_nfd", 72'(fd_q.size()), 72'(1));

    // Back-to-back frames
    do_reset();
    clear_sb();
    push_ramp(0);
    push_ramp(16);
    for (int v = 0; v < 32; v++) send_pix(v);
    idle(6);
    chk("b2b_left", 72'(exp_q.size()), 72'(0));
    chk("b2b_nwin", 72'(acc_q.size()), 72'(8));
    chk("b2b_nfd", 72'(fd_q.size()), 72'(2));
    if (fd_q.size() == 2) begin
      chk("b2b_fd0", 72'(fd_q[0]), 72'(16));
      chk("b2b_fd1", 72'(fd_q[1]), 72'(32));
    end

    // Reset mid-frame after pixel 9
    do_reset();
    clear_sb();
    for (int v = 0; v <= 9; v++) send_pix(v);
    do_reset();
    clear_sb();
    push_ramp(0);
    for (int v = 0; v < 16; v++) send_pix(v);
    idle(6);
    check_ramp("midrst", 0);

`ifdef JANELA_SOF_EN
    // Truncated frame, then a start-of-frame pixel restarts the raster
    do_reset();
    clear_sb();
    for (int v = 0; v <= 6; v++) send_pix(v);
    push_ramp(0);
    psof = 1'b1;
    send_pix(0);
    psof = 1'b0;
    for (int v = 1; v < 16; v++) send_pix(v);
    idle(6);
    check_ramp("sof", 7);
`endif

    // 8x8 random image into the sorter model
    sel = 1'b1;
    do_reset();
    clear_sb();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    for (int r = 1; r <= 6; r++)
      for (int c = 1; c <= 6; c++) begin
        mon_exp = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            mon_exp[(dr*3 + dc)*8 +: 8] = img[(r - 1 + dr)*8 + (c - 1 + dc)];
        exp_q.push_back(mon_exp);
      end
    wait_cnt = 0;
    sorter_on = 1'b1;
    for (int i = 0; i < 64; i++) send_pix(int'(img[i]));
    idle(30);
    sorter_on = 1'b0;
    jr = 1'b1;
    idle(4);
    chk("img_left", 72'(exp_q.size()), 72'(0));
    chk("img_nwin", 72'(acc_q.size()), 72'(36));
    chk("img_nfd", 72'(fd_q.size()), 72'(1));
    if (fd_q.size() > 0) chk("img_fdpos", 72'(fd_q[0]), 72'(64));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
